// File: rtl/sp_ram_pkg.sv
// Shared types for the single-port RAM arbiter.
// Channel ids are sized for the largest supported channel count.
package sp_ram_pkg;

  localparam int MAX_CH = 16;
  localparam int CH_ID_W = $clog2(MAX_CH);

  typedef logic [CH_ID_W-1:0] ch_id_t;

  typedef struct packed {
    logic   valid;
    ch_id_t id;
  } mem_tag_t;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin selector: one-hot grant starting the search at ptr.
// Pure combinational; the pointer register lives in the parent.
import sp_ram_pkg::*;

module rr_arbiter #(
  parameter int N = 4
) (
  input  logic [N-1:0] req,
  input  ch_id_t       ptr,
  output logic [N-1:0] gnt,
  output ch_id_t       idx,
  output logic         any
);

  // Walk from farthest to nearest so the nearest to ptr wins.
  always_comb begin
    gnt = '0;
    idx = '0;
    any = 1'b0;
    for (int k = N - 1; k >= 0; k--) begin
      if (req[(int'(ptr) + k) % N]) begin
        gnt = '0;
        gnt[(int'(ptr) + k) % N] = 1'b1;
        idx = ch_id_t'((int'(ptr) + k) % N);
        any = 1'b1;
      end
    end
  end

endmodule

// File: rtl/sp_ram_arbiter.sv
// Multi-channel round-robin front end for a single-port RAM.
// One registered access per cycle; read data routed back via a tag pipe.
import sp_ram_pkg::*;

module sp_ram_arbiter #(
  parameter int ADDR_WIDTH = 20,
  parameter int DATA_WIDTH = 16,
  parameter int NUM_CH     = 4,
  parameter int RD_LATENCY = 1
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [NUM_CH-1:0]            ch_req,
  input  logic [NUM_CH-1:0]            ch_we,
  input  logic [NUM_CH*ADDR_WIDTH-1:0] ch_addr,
  input  logic [NUM_CH*DATA_WIDTH-1:0] ch_wdata,
  output logic [NUM_CH-1:0]            ch_gnt,
  output logic [NUM_CH-1:0]            ch_rvalid,
  output logic [DATA_WIDTH-1:0]        ch_rdata,
  output logic                         mem_cs,
  output logic                         mem_oe,
  output logic                         mem_W_req,
  output logic [ADDR_WIDTH-1:0]        mem_addr,
  output logic [DATA_WIDTH-1:0]        mem_W_data,
  input  logic [DATA_WIDTH-1:0]        mem_R_data
);

  logic [NUM_CH-1:0]     req_m;
  logic [NUM_CH-1:0]     gnt;
  ch_id_t                idx;
  logic                  any;
  ch_id_t                ptr_q, ptr_d;
  logic                  cs_q, cs_d;
  logic                  oe_q, oe_d;
  logic                  wreq_q, wreq_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic [NUM_CH-1:0]     rvalid_q, rvalid_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
  mem_tag_t              tag_q [RD_LATENCY];
  mem_tag_t              tag_d [RD_LATENCY];
  logic                  sel_we;
  logic [ADDR_WIDTH-1:0] sel_addr;
  logic [DATA_WIDTH-1:0] sel_wdata;

  // No grants may escape while reset is held.
  assign req_m = ch_req & {NUM_CH{rst_n}};

  rr_arbiter #(.N(NUM_CH)) u_rr (
    .req (req_m),
    .ptr (ptr_q),
    .gnt (gnt),
    .idx (idx),
    .any (any)
  );

  always_comb begin
    sel_we    = 1'b0;
    sel_addr  = '0;
    sel_wdata = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (gnt[i]) begin
        sel_we    = ch_we[i];
        sel_addr  = ch_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
        sel_wdata = ch_wdata[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  always_comb begin
    ptr_d   = ptr_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    cs_d    = any;
    oe_d    = any & ~sel_we;
    wreq_d  = any & sel_we;
    if (any) begin
      ptr_d   = (idx == ch_id_t'(NUM_CH - 1)) ? '0 : idx + 1'b1;
      addr_d  = sel_addr;
      wdata_d = sel_wdata;
    end
    tag_d[0].valid = any & ~sel_we;
    tag_d[0].id    = idx;
    for (int k = 1; k < RD_LATENCY; k++) begin
      tag_d[k] = tag_q[k-1];
    end
    rvalid_d = '0;
    rdata_d  = rdata_q;
    if (tag_q[RD_LATENCY-1].valid) begin
      rvalid_d = NUM_CH'(1) << tag_q[RD_LATENCY-1].id;
      rdata_d  = mem_R_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q    <= '0;
      cs_q     <= 1'b0;
      oe_q     <= 1'b0;
      wreq_q   <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      rvalid_q <= '0;
      rdata_q  <= '0;
      for (int k = 0; k < RD_LATENCY; k++) begin
        tag_q[k] <= '0;
      end
    end else begin
      ptr_q    <= ptr_d;
      cs_q     <= cs_d;
      oe_q     <= oe_d;
      wreq_q   <= wreq_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      rvalid_q <= rvalid_d;
      rdata_q  <= rdata_d;
      for (int k = 0; k < RD_LATENCY; k++) begin
        tag_q[k] <= tag_d[k];
      end
    end
  end

  assign ch_gnt     = gnt;
  assign ch_rvalid  = rvalid_q;
  assign ch_rdata   = rdata_q;
  assign mem_cs     = cs_q;
  assign mem_oe     = oe_q;
  assign mem_W_req  = wreq_q;
  assign mem_addr   = addr_q;
  assign mem_W_data = wdata_q;

endmodule

// File: tb/tb_sp_ram_arbiter.sv
// Directed bench for sp_ram_arbiter with an async-read RAM model.
// Four channels, one-cycle read latency.
module tb_sp_ram_arbiter;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [3:0]  ch_req = '0;
  logic [3:0]  ch_we = '0;
  logic [79:0] ch_addr = '0;
  logic [63:0] ch_wdata = '0;
  logic [3:0]  ch_gnt;
  logic [3:0]  ch_rvalid;
  logic [15:0] ch_rdata;
  logic        mem_cs;
  logic        mem_oe;
  logic        mem_W_req;
  logic [19:0] mem_addr;
  logic [15:0] mem_W_data;
  logic [15:0] mem_R_data;

  int total = 0;
  int bad = 0;

  logic [15:0] mem [256];

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (mem_cs && mem_W_req) mem[mem_addr[7:0]] <= mem_W_data;
  end
  assign mem_R_data = mem_oe ? mem[mem_addr[7:0]] : 16'h0;

  sp_ram_arbiter #(
    .ADDR_WIDTH(20), .DATA_WIDTH(16), .NUM_CH(4), .RD_LATENCY(1)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .ch_req(ch_req), .ch_we(ch_we),
    .ch_addr(ch_addr), .ch_wdata(ch_wdata),
    .ch_gnt(ch_gnt), .ch_rvalid(ch_rvalid), .ch_rdata(ch_rdata),
    .mem_cs(mem_cs), .mem_oe(mem_oe), .mem_W_req(mem_W_req),
    .mem_addr(mem_addr), .mem_W_data(mem_W_data),
    .mem_R_data(mem_R_data)
  );

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    ch_req = 4'hF;
    #3;
    total++;
    if (ch_gnt !== 4'b0) begin
      bad++; $display("FAIL rst_gnt got=%b exp=0000", ch_gnt);
    end
    cyc();
    total++;
    if ({mem_cs, mem_oe, mem_W_req} !== 3'b000) begin
      bad++; $display("FAIL rst_ctl got=%b exp=000", {mem_cs, mem_oe, mem_W_req});
    end
    total++;
    if (mem_addr !== 20'h0 || mem_W_data !== 16'h0) begin
      bad++; $display("FAIL rst_bus got=%h/%h exp=0/0", mem_addr, mem_W_data);
    end
    total++;
    if (ch_rvalid !== 4'b0 || ch_rdata !== 16'h0) begin
      bad++; $display("FAIL rst_rd got=%b/%h exp=0000/0", ch_rvalid, ch_rdata);
    end
    total++;
    if (dut.ptr_q !== 4'd0) begin
      bad++; $display("FAIL rst_ptr got=%0d exp=0", dut.ptr_q);
    end
    ch_req = '0;
    rst_n = 1'b1;
    cyc();
  endtask

  task automatic test_rr_order();
    logic [3:0] exp;
    for (int i = 0; i < 4; i++) begin
      ch_addr[i*20 +: 20] = 20'h20 + 20'(i);
      mem[8'h20 + 8'(i)] = 16'hA000 + 16'(i);
    end
    ch_we = '0;
    ch_req = 4'hF;
    for (int k = 0; k < 8; k++) begin
      #1;
      exp = 4'b1 << (k % 4);
      total++;
      if (ch_gnt !== exp) begin
        bad++; $display("FAIL rr_gnt[%0d] got=%b exp=%b", k, ch_gnt, exp);
      end
      if (k >= 1) begin
        total++;
        if (mem_cs !== 1'b1) begin
          bad++; $display("FAIL rr_cs[%0d] got=%b exp=1", k, mem_cs);
        end
      end
      if (k >= 2) begin
        exp = 4'b1 << ((k - 2) % 4);
        total++;
        if (ch_rvalid !== exp || ch_rdata !== 16'hA000 + 16'((k - 2) % 4)) begin
          bad++;
          $display("FAIL rr_rd[%0d] got=%b/%h exp=%b/%h", k, ch_rvalid,
                   ch_rdata, exp, 16'hA000 + 16'((k - 2) % 4));
        end
      end
      cyc();
    end
    ch_req = '0;
    #1;
    total++;
    if (ch_gnt !== 4'b0 || ch_rvalid !== 4'b0100 || ch_rdata !== 16'hA002) begin
      bad++; $display("FAIL rr_tail0 got=%b/%b/%h exp=0000/0100/a002",
                      ch_gnt, ch_rvalid, ch_rdata);
    end
    cyc();
    total++;
    if (ch_rvalid !== 4'b1000 || ch_rdata !== 16'hA003 || mem_cs !== 1'b0) begin
      bad++; $display("FAIL rr_tail1 got=%b/%h/%b exp=1000/a003/0",
                      ch_rvalid, ch_rdata, mem_cs);
    end
    total++;
    if (dut.ptr_q !== 4'd0) begin
      bad++; $display("FAIL rr_ptr got=%0d exp=0", dut.ptr_q);
    end
    cyc();
  endtask

  task automatic test_single_read();
    mem[8'h10] = 16'hBEEF;
    ch_addr[2*20 +: 20] = 20'h10;
    ch_addr[0 +: 20] = 20'h77;
    ch_we = 4'b0001;
    ch_req = 4'b0100;
    #1;
    total++;
    if (ch_gnt !== 4'b0100) begin
      bad++; $display("FAIL rd_gnt got=%b exp=0100", ch_gnt);
    end
    cyc();
    ch_req = '0;
    #1;
    total++;
    if ({mem_cs, mem_oe, mem_W_req} !== 3'b110 || mem_addr !== 20'h10) begin
      bad++; $display("FAIL rd_cmd got=%b/%h exp=110/00010",
                      {mem_cs, mem_oe, mem_W_req}, mem_addr);
    end
    total++;
    if (ch_rvalid !== 4'b0) begin
      bad++; $display("FAIL rd_early got=%b exp=0000", ch_rvalid);
    end
    cyc();
    total++;
    if (ch_rvalid !== 4'b0100 || ch_rdata !== 16'hBEEF) begin
      bad++; $display("FAIL rd_data got=%b/%h exp=0100/beef", ch_rvalid, ch_rdata);
    end
    cyc();
    total++;
    if (ch_rvalid !== 4'b0 || dut.ptr_q !== 4'd3) begin
      bad++; $display("FAIL rd_after got=%b/%0d exp=0000/3", ch_rvalid, dut.ptr_q);
    end
  endtask

  task automatic test_ptr_wrap();
    ch_we = '0;
    ch_req = 4'b1001;
    #1;
    total++;
    if (ch_gnt !== 4'b1000) begin
      bad++; $display("FAIL wrap_gnt0 got=%b exp=1000", ch_gnt);
    end
    cyc();
    ch_req = 4'b0001;
    #1;
    total++;
    if (ch_gnt !== 4'b0001) begin
      bad++; $display("FAIL wrap_gnt1 got=%b exp=0001", ch_gnt);
    end
    cyc();
    ch_req = '0;
    #1;
    total++;
    if (dut.ptr_q !== 4'd1) begin
      bad++; $display("FAIL wrap_ptr got=%0d exp=1", dut.ptr_q);
    end
    cyc();
    cyc();
  endtask

  task automatic test_write_read();
    ch_we = 4'b0010;
    ch_addr[1*20 +: 20] = 20'h5;
    ch_wdata[1*16 +: 16] = 16'h1234;
    ch_addr[3*20 +: 20] = 20'h5;
    ch_req = 4'b0010;
    #1;
    total++;
    if (ch_gnt !== 4'b0010) begin
      bad++; $display("FAIL wr_gnt got=%b exp=0010", ch_gnt);
    end
    cyc();
    ch_req = 4'b1000;
    #1;
    total++;
    if ({mem_cs, mem_oe, mem_W_req} !== 3'b101 || mem_W_data !== 16'h1234) begin
      bad++; $display("FAIL wr_cmd got=%b/%h exp=101/1234",
                      {mem_cs, mem_oe, mem_W_req}, mem_W_data);
    end
    total++;
    if (ch_gnt !== 4'b1000) begin
      bad++; $display("FAIL wr_rd_gnt got=%b exp=1000", ch_gnt);
    end
    cyc();
    ch_req = '0;
    #1;
    total++;
    if (ch_rvalid !== 4'b0) begin
      bad++; $display("FAIL wr_norv got=%b exp=0000", ch_rvalid);
    end
    cyc();
    total++;
    if (ch_rvalid !== 4'b1000 || ch_rdata !== 16'h1234) begin
      bad++; $display("FAIL wr_rd got=%b/%h exp=1000/1234", ch_rvalid, ch_rdata);
    end
    cyc();
  endtask

  task automatic test_idle();
    ch_req = '0;
    for (int k = 0; k < 5; k++) begin
      cyc();
      total++;
      if (mem_cs !== 1'b0 || ch_rvalid !== 4'b0 || mem_addr !== 20'h5) begin
        bad++; $display("FAIL idle[%0d] got=%b/%b/%h exp=0/0000/00005",
                        k, mem_cs, ch_rvalid, mem_addr);
      end
    end
  endtask

  task automatic test_reset_inflight();
    ch_we = '0;
    ch_req = 4'b0100;
    cyc();
    ch_req = '0;
    rst_n = 1'b0;
    #1;
    total++;
    if ({mem_cs, mem_oe, mem_W_req} !== 3'b000 || ch_rvalid !== 4'b0 ||
        mem_addr !== 20'h0 || ch_rdata !== 16'h0 || dut.ptr_q !== 4'd0) begin
      bad++; $display("FAIL rst_fl got=%b/%b/%h/%h/%0d exp=000/0000/0/0/0",
                      {mem_cs, mem_oe, mem_W_req}, ch_rvalid, mem_addr,
                      ch_rdata, dut.ptr_q);
    end
    cyc();
    rst_n = 1'b1;
    for (int k = 0; k < 3; k++) begin
      cyc();
      total++;
      if (ch_rvalid !== 4'b0 || mem_cs !== 1'b0) begin
        bad++; $display("FAIL rst_fl_rv[%0d] got=%b/%b exp=0000/0",
                        k, ch_rvalid, mem_cs);
      end
    end
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 16'h0;
    test_reset();
    test_rr_order();
    test_single_read();
    test_ptr_wrap();
    test_write_read();
    test_idle();
    test_reset_inflight();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
